// File: rtl/gcd_pkg.sv
// gcd_pkg: definitions shared by the GCD operand dispatcher and its FIFO.
//   GCD_WIDTH        - operand/result width of the gcd_top core
//   GCD_TMO_W        - default watchdog counter width
//   gcd_disp_state_t - dispatcher FSM state encoding
package gcd_pkg;

    localparam int GCD_WIDTH = 16;
    localparam int GCD_TMO_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } gcd_disp_state_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo: operand-triple FIFO, one {A,B,C} entry per slot.
//   clk, reset  - clock, synchronous active-low reset (flushes pointers/count)
//   push        - write push_data at the tail (caller guarantees not full)
//   push_data   - {A,B,C} triple, 3*WIDTH bits
//   pop         - drop the head entry (caller guarantees not empty)
//   head        - current head entry
//   count       - occupancy, 0..DEPTH
module gcd_op_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [3*WIDTH-1:0]       push_data,
    input  logic                     pop,
    output logic [3*WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [3*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a flush empties it through the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: buffers {A,B,C} triples and issues them one at a time to the
// gcd_top core, returning results in order on a valid/ready port.
//   clk, reset              - clock, synchronous active-low reset
//   in_valid/in_ready       - upstream triple handshake; in_a/in_b/in_c operands
//   core_start              - one-cycle start pulse to the core
//   core_a/core_b/core_c    - operands to the core, stable until result capture
//   core_valid/core_d       - core result
//   out_valid/out_ready     - downstream result handshake
//   out_d, out_err          - result; out_err marks a watchdog-generated result
//   count                   - FIFO occupancy
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = 4,
    parameter int TMO_W = GCD_TMO_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    input  logic [WIDTH-1:0]        in_c,
    output logic                    core_start,
    output logic [WIDTH-1:0]        core_a,
    output logic [WIDTH-1:0]        core_b,
    output logic [WIDTH-1:0]        core_c,
    input  logic                    core_valid,
    input  logic [WIDTH-1:0]        core_d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_d,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    gcd_disp_state_t    state, state_nx;
    logic [TMO_W-1:0]   wdog;
    logic               push, pop;
    logic [3*WIDTH-1:0] head;

    // Ready comes from the registered count only, so a full FIFO never
    // takes a push even in the cycle it pops.
    assign in_ready = reset && (count < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == ISSUE);

    gcd_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_a, in_b, in_c}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state. core_valid is not looked at in ISSUE: the core may still
    // be holding its done level from the previous job.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (count != '0) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (core_valid || (&wdog)) state_nx = HOLD;
            HOLD:  if (out_ready) state_nx = (count != '0) ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        core_start = (state == ISSUE);
        out_valid  = (state == HOLD);
    end

    // Operands are loaded on the edge entering ISSUE so they are valid
    // alongside core_start; watchdog and result registers follow the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_a  <= '0;
            core_b  <= '0;
            core_c  <= '0;
            wdog    <= '0;
            out_d   <= '0;
            out_err <= 1'b0;
        end else begin
            if (state_nx == ISSUE) {core_a, core_b, core_c} <= head;

            if (state == ISSUE)     wdog <= '0;
            else if (state == WAIT) wdog <= wdog + 1'b1;

            if (state == WAIT) begin
                if (core_valid) begin
                    out_d   <= core_d;
                    out_err <= 1'b0;
                end else if (&wdog) begin
                    out_d   <= '0;
                    out_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
module tb_gcd_dispatch;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic         core_start;
    logic [W-1:0] core_a, core_b, core_c;
    logic         core_valid;
    logic [W-1:0] core_d;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_d;
    logic         out_err;
    logic [2:0]   count;

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;

    gcd_dispatch #(.WIDTH(W), .DEPTH(D), .TMO_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .core_valid(core_valid), .core_d(core_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for gcd_top: result after core_lat+1 cycles,
    // done level held until the next start (so it is stale during ISSUE).
    logic         busy;
    int           cnt;
    int           core_lat = 2;
    bit           core_dead = 1'b0;
    logic [W-1:0] ma, mb, mc;

    function automatic logic [W-1:0] gcd2(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            core_valid <= 1'b0;
            core_d     <= '0;
            busy       <= 1'b0;
            cnt        <= 0;
        end else if (core_start) begin
            core_valid <= 1'b0;
            busy       <= !core_dead;
            cnt        <= core_lat;
            ma <= core_a; mb <= core_b; mc <= core_c;
        end else if (busy) begin
            if (cnt == 0) begin
                core_valid <= 1'b1;
                core_d     <= gcd2(gcd2(ma, mb), mc);
                busy       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk) if (reset && core_start) n_start <= n_start + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so callers can chain back-to-back pushes.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c;
        chk("push_rdy", in_ready, 1);
        step();
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic hshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int s0, k;
        logic [W-1:0] exp_d [5];
        exp_d[0] = 4; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 5; exp_d[4] = 6;

        // reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", core_start, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_d", out_d, 0);
        chk("rst_err", out_err, 0);
        chk("rst_count", count, 0);
        chk("rst_core_a", core_a, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // single job
        push(16, 8, 4);
        in_valid = 1'b0;
        chk("sj_start_e0", core_start, 0);
        chk("sj_count", count, 1);
        s0 = n_start;
        step();
        chk("sj_start_e1", core_start, 1);
        chk("sj_core_a", core_a, 16);
        chk("sj_core_b", core_b, 8);
        chk("sj_core_c", core_c, 4);
        step();
        chk("sj_start_e2", core_start, 0);
        wait_out("sj_ov");
        chk("sj_d", out_d, 4);
        chk("sj_err", out_err, 0);
        chk("sj_nstart", n_start - s0, 1);
        hshake();
        chk("sj_ov_drop", out_valid, 0);

        // burst with downstream stall
        push(16, 8, 4);
        push(3571, 2711, 1543);
        push(479, 654, 217);
        in_valid = 1'b0;
        wait_out("bs_ov");
        chk("bs_count", count, 2);
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 2);
            if (i == 0) begin in_a = 345; in_b = 765; in_c = 95; end
            if (i == 1) begin in_a = 12;  in_b = 18;  in_c = 30; end
            step();
            chk("stall_ov", out_valid, 1);
            chk("stall_d", out_d, 4);
            chk("stall_count", count, (i == 0) ? 3 : 4);
        end
        chk("stall_nostart", n_start - s0, 0);
        in_valid = 1'b1;
        in_a = 1; in_b = 2; in_c = 3;
        chk("full_rdy", in_ready, 0);
        step();
        chk("full_count", count, 4);
        in_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_out("drain_ov");
            chk("drain_d", out_d, exp_d[i]);
            chk("drain_err", out_err, 0);
            hshake();
            if (i == 0) begin
                // core still shows its old done level during this ISSUE
                chk("stale_start", core_start, 1);
                step();
                chk("stale_ov", out_valid, 0);
            end
            if (i == 4) chk("drain_idle", core_start, 0);
        end

        // timeout: core never answers
        core_dead = 1'b1;
        push(7, 14, 21);
        in_valid = 1'b0;
        step();
        chk("tmo_start", core_start, 1);
        k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        chk("tmo_cycles", k, 17);
        chk("tmo_err", out_err, 1);
        chk("tmo_d", out_d, 0);
        hshake();
        core_dead = 1'b0;
        push(12, 18, 30);
        in_valid = 1'b0;
        wait_out("post_tmo_ov");
        chk("post_tmo_d", out_d, 6);
        chk("post_tmo_err", out_err, 0);
        hshake();

        // reset in the middle of WAIT with three queued
        core_lat = 8;
        push(16, 8, 4);
        push(3571, 2711, 1543);
        push(479, 654, 217);
        push(345, 765, 95);
        in_valid = 1'b0;
        chk("rw_count_pre", count, 3);
        chk("rw_wait", core_start | out_valid, 0);
        reset = 1'b0;
        step();
        chk("rw_start", core_start, 0);
        chk("rw_core_a", core_a, 0);
        chk("rw_core_b", core_b, 0);
        chk("rw_core_c", core_c, 0);
        chk("rw_ov", out_valid, 0);
        chk("rw_d", out_d, 0);
        chk("rw_err", out_err, 0);
        chk("rw_count", count, 0);
        chk("rw_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("rw_rel_rdy", in_ready, 1);
        s0 = n_start;
        k = 0;
        repeat (30) begin
            step();
            if (out_valid) k++;
        end
        chk("rw_spurious_ov", k, 0);
        chk("rw_spurious_start", n_start - s0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
